// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_t : sequencer states (IDLE, RUN, DONE)
//   OP_ADD  : op encoding for a + b + cin
//   OP_SUB  : op encoding for a - b
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/response bundle between the ALU decoder and the serial adder.
//   master : drives start/op/a/b/cin, observes busy/done/result/cout/ovf
//   slave  : the sequencer side (opposite directions)
// Parameter WIDTH : operand/result width in bits.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, cout, ovf
  );

endinterface : serial_add_ctrl_if

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa
// 1-bit full adder.
//   a, b : addend bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule : fa

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract sequencer driving one full adder LSB first over
// WIDTH cycles, with a start/busy/done handshake.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : serial_add_ctrl_if.slave (start/op/a/b/cin in,
//            busy/done/result/cout/ovf out)
// Parameter WIDTH (2..32) : operand/result width.
// Optional build macro ALU_SAT_EN : saturate result on signed overflow
// (ovf and cout still report the raw values).
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] final_sum;

  fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum of the bit being processed completes the shifted result.
  assign final_sum = {fa_s, res_sh[WIDTH-1:1]};

  // Next-state decode, start acceptance and last-bit detection.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          next_state = RUN;
          accept     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          next_state = DONE;
          last_bit   = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand shift registers, carry flop and bit counter.
  // Subtract is a + ~b + 1, so b is inverted and the carry preset on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= {WIDTH{1'b0}};
      b_sh   <= {WIDTH{1'b0}};
      res_sh <= {WIDTH{1'b0}};
      carry  <= 1'b0;
      cnt    <= {CW{1'b0}};
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
      carry  <= (bus.op == OP_SUB) ? 1'b1 : bus.cin;
      cnt    <= {CW{1'b0}};
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= final_sum;
      carry  <= fa_co;
      cnt    <= cnt + CW'(1);
    end
  end

  // Handshake flags and the held result/flags of the last completed op.
  // On the last bit 'carry' is the carry into the MSB, so ovf = carry ^ co.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= {WIDTH{1'b0}};
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      bus.busy <= (next_state == RUN);
      bus.done <= (next_state == DONE);
      if (last_bit) begin
        bus.cout <= fa_co;
        bus.ovf  <= carry ^ fa_co;
`ifdef ALU_SAT_EN
        // a_sh[0] holds the original MSB of a on the last bit.
        if (carry ^ fa_co) begin
          bus.result <= a_sh[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          bus.result <= final_sum;
        end
`else
        bus.result <= final_sum;
`endif
      end
    end
  end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH = 8): directed cases with
// literal expectations plus randomized traffic compared every cycle against
// an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic chk_en;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: returns {cout, ovf, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic op, input logic cin);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    if (op == 1'b0) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      r    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r  = a - b;
      co = (a >= b);
      ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
`ifdef ALU_SAT_EN
    if (ov) r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {co, ov, r};
  endfunction

  // Behavioural model: busy for W cycles after an accepted start, then a
  // one-cycle done with the precomputed answer.
  logic         m_busy, m_done, m_cout, m_ovf, p_cout, p_ovf;
  logic [W-1:0] m_res, p_res;
  int           m_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      m_res  <= '0;   m_cout <= 1'b0; m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_res  <= p_res; m_cout <= p_cout; m_ovf <= p_ovf;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (bus.start) begin
        {p_cout, p_ovf, p_res} <= ref_op(bus.a, bus.b, bus.op, bus.cin);
        m_busy <= 1'b1;
        m_left <= W;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (bus.busy !== m_busy || bus.done !== m_done || bus.result !== m_res ||
          bus.cout !== m_cout || bus.ovf !== m_ovf) begin
        miscompares++;
        $display("FAIL model t=%0t busy=%b/%b done=%b/%b result=%h/%h cout=%b/%b ovf=%b/%b (got/expected)",
                 $time, bus.busy, m_busy, bus.done, m_done, bus.result, m_res,
                 bus.cout, m_cout, bus.ovf, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Launch one op and wait for done; lat = negedges from launch to done.
  // If intr_at > 0, pulse start with junk operands that many cycles in.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       input logic cin, input int intr_at, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.op = op; bus.cin = cin;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      if (lat == intr_at) begin
        bus.start = 1'b1; bus.a = 8'd99; bus.b = 8'd99; bus.op = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      miscompares++;
      $display("FAIL timeout waiting for done a=%h b=%h", a, b);
    end
  endtask

  int lat;
  int lat2;
  int done_seen;

  initial begin
    vectors = 0; miscompares = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", {24'd0, bus.result}, 32'd0);
    chk("reset_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
    rst_n = 1'b1;

    do_op(8'd100, 8'd27, 1'b0, 1'b0, 0, lat);
    chk("add_latency", lat, W + 1);
    chk("add_result", {24'd0, bus.result}, 32'd127);
    chk("add_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);

    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, lat);
`ifdef ALU_SAT_EN
    chk("ovf_result", {24'd0, bus.result}, 32'h7F);
`else
    chk("ovf_result", {24'd0, bus.result}, 32'h80);
`endif
    chk("ovf_flags", {30'd0, bus.cout, bus.ovf}, 32'd1);

    do_op(8'd5, 8'd7, 1'b1, 1'b1, 0, lat);
    chk("sub_borrow_result", {24'd0, bus.result}, 32'hFE);
    chk("sub_borrow_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);

    do_op(8'd7, 8'd5, 1'b1, 1'b0, 0, lat);
    chk("sub_result", {24'd0, bus.result}, 32'h02);
    chk("sub_flags", {30'd0, bus.cout, bus.ovf}, 32'd2);

    do_op(8'hFF, 8'h01, 1'b0, 1'b1, 0, lat);
    chk("carry_result", {24'd0, bus.result}, 32'h01);
    chk("carry_flags", {30'd0, bus.cout, bus.ovf}, 32'd2);

    do_op(8'd10, 8'd20, 1'b0, 1'b0, 3, lat);
    chk("ignore_start_result", {24'd0, bus.result}, 32'd30);
    chk("ignore_start_latency", lat, W + 1);

    // Back-to-back: start held through RUN and DONE.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd2; bus.op = 1'b0; bus.cin = 1'b0;
    @(negedge clk);
    bus.a = 8'd50; bus.b = 8'd8; bus.op = 1'b1;
    lat = 1;
    while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_first_result", {24'd0, bus.result}, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    lat2 = 1;
    while (!bus.done && lat2 < 40) begin @(negedge clk); lat2++; end
    chk("b2b_done_spacing", lat2, W + 1);
    chk("b2b_second_result", {24'd0, bus.result}, 32'd42);
    chk("b2b_second_flags", {30'd0, bus.cout, bus.ovf}, 32'd2);

    // Reset during the 4th RUN cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd27; bus.op = 1'b0; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_result", {24'd0, bus.result}, 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("rst_mid_no_done", done_seen, 0);
    do_op(8'd100, 8'd27, 1'b0, 1'b0, 0, lat);
    chk("after_rst_result", {24'd0, bus.result}, 32'd127);

    // Randomized traffic, including starts while busy and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.op    = 1'($urandom);
      bus.cin   = 1'($urandom);
      rst_n     = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer. Drives a single 1-bit full adder (`fa`) over WIDTH cycles, LSB first, with a carry flop between bits.
- Gives the ALU an area-minimal adder path with a start/busy/done handshake.
- Sits between the ALU opcode decoder and the result mux.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk     input   1      rising-edge clock
- rst_n   input   1      synchronous reset, active-low
- start   input   1      request; accepted only when state != RUN
- op      input   1      0 = add (a+b+cin), 1 = subtract (a-b)
- a       input   WIDTH  operand A, sampled on accepted start
- b       input   WIDTH  operand B, sampled on accepted start
- cin     input   1      carry-in for add; ignored for subtract
- busy    output  1      high while in RUN
- done    output  1      one-cycle pulse when result is valid
- result  output  WIDTH  last completed result, held until next done
- cout    output  1      final carry; for subtract, 1 = no borrow
- ovf     output  1      signed two's-complement overflow of last op

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal shift regs, carry and counter cleared.
- States and transitions:
  - IDLE: start=1 -> RUN.
  - RUN: WIDTH cycles; after the final bit -> DONE.
  - DONE: one cycle. start=1 -> RUN (back-to-back); otherwise -> IDLE.
- On accepted start:
  - a_sh <= a.
  - b_sh <= op ? ~b : b.
  - carry <= op ? 1 : cin.
  - cnt <= 0.
- RUN, each cycle:
  - `fa` inputs are a_sh[0], b_sh[0], carry.
  - Sum shifts into the MSB of the result shift reg; a_sh and b_sh shift right by 1.
  - carry <= fa carry-out; cnt++.
  - On cnt==WIDTH-1, capture c_msb_in = carry (carry into the MSB bit).
- Entering DONE (same edge as the last RUN bit):
  - result <= completed shift reg.
  - cout <= final carry.
  - ovf <= c_msb_in ^ final carry.
- done=1 only in DONE; busy=1 only in RUN.
- Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH.
- Throughput: one op per WIDTH+1 cycles.
- start while busy=1: ignored, no queuing; a/b/op/cin changes during RUN have no effect.
- start during DONE: new operands latched and RUN entered. done still pulses for the finishing op; result/cout/ovf hold its values until the next DONE.
- Reset mid-RUN: operation aborted; done not asserted for it; all outputs return to reset values.
- Arithmetic wraps modulo 2^WIDTH (unless ALU_SAT_EN is defined).

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: when ovf would be 1, result saturates instead of wrapping.
  - Positive overflow (a MSB = 0): result = 0111..1.
  - Negative overflow (a MSB = 1): result = 1000..0.
  - ovf and cout still report raw values.
- Undefined: result wraps; no saturation logic is synthesized.

Decomposition:
- Shared package alu_pkg:
  - state typedef: IDLE, RUN, DONE.
  - op encoding constants: OP_ADD = 1'b0, OP_SUB = 1'b1.
- One sub-module: the existing `fa` 1-bit full adder, instantiated once (ports a, b, c, s, co).
- Counter width is $clog2(WIDTH)+1, computed locally.

Test Plan:
- Add, WIDTH=8: a=100, b=27, cin=0, op=0, start at edge N -> done in cycle after edge N+8; result=8'd127, cout=0, ovf=0.
- Signed overflow: a=8'h7F, b=8'h01, op=0 -> result=8'h80, ovf=1, cout=0. With ALU_SAT_EN: result=8'h7F.
- Subtract with borrow: a=5, b=7, op=1 -> result=8'hFE, cout=0, ovf=0. Also a=7, b=5 -> result=8'h02, cout=1.
- Carry chain: a=8'hFF, b=8'h01, cin=1, op=0 -> result=8'h01, cout=1, ovf=0.
- Handshake: start pulsed during RUN with other operands -> ignored, result unchanged. Start held during DONE -> second op begins with no idle cycle; both done pulses observed 9 cycles apart.
- Reset mid-op: rst_n=0 at the 4th RUN cycle -> busy=0, done never pulses, result=0; next start runs normally.
